// File: rtl/fx68k_ea_ext_seq.sv
// Effective-address extension sequencer: decodes NCH EA fields and pulls their
// extension words from the prefetch queue in channel order, flagging invalid EAs early.
module fx68k_ea_ext_seq #(
  parameter int NCH       = 2,
  parameter bit USE_CLKEN = 1'b1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              enPhi1,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6*NCH-1:0]  req_ea,
  input  logic [NCH-1:0]    req_en,
  input  logic [1:0]        req_size,
  input  logic              ext_valid,
  input  logic [15:0]       ext_word,
  output logic              ext_ack,
  output logic [4*NCH-1:0]  ea_mode,
  output logic [2*NCH-1:0]  ea_nwords,
  output logic [32*NCH-1:0] ea_ext,
  output logic              busy,
  output logic              done,
  output logic              ill,
  output logic [1:0]        ill_ch
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [3:0] EA_REL_AN = 4'd5;
  localparam logic [3:0] EA_IDX_AN = 4'd6;
  localparam logic [3:0] EA_ABS_W  = 4'd7;
  localparam logic [3:0] EA_ABS_L  = 4'd8;
  localparam logic [3:0] EA_REL_PC = 4'd9;
  localparam logic [3:0] EA_IDX_PC = 4'd10;
  localparam logic [3:0] EA_IMM    = 4'd11;
  localparam logic [3:0] EA_INV    = 4'd12;

  typedef enum logic [1:0] {IDLE, SEQ, DONE, ILL} state_t;

  state_t state, state_nx;

  logic                  en;
  logic [NCH-1:0][5:0]   ea_q;
  logic [NCH-1:0]        en_q;
  logic [1:0]            size_q;
  logic [CW-1:0]         ch;
  logic [CW-1:0]         ill_ch_q;
  logic [NCH-1:0][3:0]   mode_q;
  logic [NCH-1:0][1:0]   nw_q;
  logic [NCH-1:0][31:0]  ext_q;

  logic [3:0] cur_mode;
  logic [1:0] cur_need;
  logic       cur_on;
  logic       cur_inv;
  logic       need_more;
  logic       take;
  logic       ch_done;
  logic       last;

  function automatic logic [3:0] ea_decode(input logic [5:0] f);
    logic [3:0] m;
    if (f[5:3] != 3'b111) begin
      m = {1'b0, f[5:3]};
    end else begin
      case (f[2:0])
        3'b000:  m = EA_ABS_W;
        3'b001:  m = EA_ABS_L;
        3'b010:  m = EA_REL_PC;
        3'b011:  m = EA_IDX_PC;
        3'b100:  m = EA_IMM;
        default: m = EA_INV;
      endcase
    end
    return m;
  endfunction

  function automatic logic [1:0] ea_words(input logic [3:0] m, input logic [1:0] sz);
    logic [1:0] n;
    case (m)
      EA_REL_AN, EA_IDX_AN, EA_ABS_W, EA_REL_PC, EA_IDX_PC: n = 2'd1;
      EA_ABS_L: n = 2'd2;
      EA_IMM:   n = sz[1] ? 2'd2 : 2'd1;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

  assign en = USE_CLKEN ? enPhi1 : 1'b1;

  always_comb begin
    cur_mode  = ea_decode(ea_q[ch]);
    cur_need  = ea_words(cur_mode, size_q);
    cur_on    = en_q[ch];
    cur_inv   = cur_on && (cur_mode == EA_INV);
    need_more = cur_on && !cur_inv && (nw_q[ch] != cur_need);
    take      = (state == SEQ) && need_more && ext_valid && en && !flush;
    // A channel with no words still occupies one SEQ cycle.
    ch_done   = !cur_on || (cur_need == 2'd0) || (take && (nw_q[ch] + 2'd1 == cur_need));
    last      = (ch == CW'(NCH - 1));
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else if (en) begin
      case (state)
        IDLE: if (req_valid) state_nx = SEQ;
        SEQ: begin
          if (cur_inv)              state_nx = ILL;
          else if (ch_done && last) state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE) && !flush;
    ill       = (state == ILL) && !flush;
    ext_ack   = take;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ea_q     <= '0;
      en_q     <= '0;
      size_q   <= '0;
      ch       <= '0;
      ill_ch_q <= '0;
      mode_q   <= '0;
      nw_q     <= '0;
      ext_q    <= '0;
    end else if (en && !flush) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ea_q   <= req_ea;
            en_q   <= req_en;
            size_q <= req_size;
            nw_q   <= '0;
            ext_q  <= '0;
            ch     <= '0;
          end
        end
        SEQ: begin
          mode_q[ch] <= cur_mode;
          if (cur_inv) begin
            ill_ch_q <= ch;
          end else begin
            // Shifting in keeps 1-word results low-aligned and 2-word results first-word-high.
            if (take) begin
              ext_q[ch] <= {ext_q[ch][15:0], ext_word};
              nw_q[ch]  <= nw_q[ch] + 2'd1;
            end
            if (ch_done && !last) ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ea_mode   = mode_q;
  assign ea_nwords = nw_q;
  assign ea_ext    = ext_q;
  assign ill_ch    = 2'(ill_ch_q);

endmodule
